// File: rtl/gf409_pkg.sv
// rtl/gf409_pkg.sv - GF(2^409) field constants for the x^409 + x^87 + 1 reduction path
package gf409_pkg;
  localparam int GF_M       = 409;
  localparam int GF_K       = 87;
  localparam int GF_PROD_W  = 817;
  localparam int GF_FOLD1_W = 495;
endpackage

// File: rtl/gf409_fold.sv
// rtl/gf409_fold.sv - combinational trinomial fold: low M bits ^ H ^ (H << K), H = bits above M
module gf409_fold
  import gf409_pkg::*;
#(
  parameter int IN_W  = GF_PROD_W,
  // Wide enough to hold H << K; never narrower than a field element.
  parameter int OUT_W = ((IN_W - GF_M + GF_K) > GF_M) ? (IN_W - GF_M + GF_K) : GF_M
) (
  input  logic [IN_W-1:0]  in_data,
  output logic [OUT_W-1:0] out_data
);

  logic [OUT_W-1:0] lo_ext;
  logic [OUT_W-1:0] hi_ext;

  // x^M == x^K + 1, so every coefficient above x^(M-1) lands twice: at i-M and i-M+K.
  assign lo_ext   = OUT_W'(in_data[GF_M-1:0]);
  assign hi_ext   = OUT_W'(in_data[IN_W-1:GF_M]);
  assign out_data = lo_ext ^ hi_ext ^ (hi_ext << GF_K);

endmodule

// File: rtl/gf409_reduce.sv
// rtl/gf409_reduce.sv - two-stage GF(2^409) reduction pipeline; GF409_REDUCE_PERF_EN adds out_count
module gf409_reduce
  import gf409_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [GF_PROD_W-1:0] in_prod,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [GF_M-1:0]      out_res
`ifdef GF409_REDUCE_PERF_EN
  ,
  output logic [31:0]          out_count
`endif
);

  logic [GF_FOLD1_W-1:0] t_q, t_d;
  logic [GF_M-1:0]       res_q, res_d;
  logic                  v1_q, v1_d;
  logic                  v2_q, v2_d;
  logic [GF_FOLD1_W-1:0] fold1;
  logic [GF_M-1:0]       fold2;
  logic                  ready1, ready2;
  logic                  load1, load2;

  gf409_fold #(.IN_W(GF_PROD_W), .OUT_W(GF_FOLD1_W)) u_fold1 (
    .in_data  (in_prod),
    .out_data (fold1)
  );

  gf409_fold #(.IN_W(GF_FOLD1_W), .OUT_W(GF_M)) u_fold2 (
    .in_data  (t_q),
    .out_data (fold2)
  );

  // Ready propagates backwards so a bubble in either stage is filled immediately.
  always_comb begin
    ready2 = !v2_q || out_ready;
    ready1 = !v1_q || ready2;
    load1  = in_valid && ready1;
    load2  = v1_q && ready2;
  end

  assign in_ready  = ready1;
  assign out_valid = v2_q;
  assign out_res   = res_q;

  // Next-state for valid bits and data registers; data only moves on its stage enable.
  always_comb begin
    v1_d  = v1_q;
    v2_d  = v2_q;
    t_d   = t_q;
    res_d = res_q;
    if (load1) begin
      v1_d = 1'b1;
      t_d  = fold1;
    end else if (load2) begin
      v1_d = 1'b0;
    end
    if (load2) begin
      v2_d  = 1'b1;
      res_d = fold2;
    end else if (out_ready) begin
      v2_d = 1'b0;
    end
  end

  // Stage registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      t_q   <= '0;
      res_q <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      t_q   <= t_d;
      res_q <= res_d;
    end
  end

`ifdef GF409_REDUCE_PERF_EN
  logic [31:0] count_q, count_d;

  // Count delivered results, sticking at all-ones rather than wrapping.
  always_comb begin
    count_d = count_q;
    if (v2_q && out_ready && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  // Completed-reduction counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out_count = count_q;
`endif

endmodule

// File: tb/tb_gf409_reduce.sv
// tb/tb_gf409_reduce.sv - scoreboard bench for gf409_reduce; honours GF409_REDUCE_PERF_EN
module tb_gf409_reduce;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [816:0] in_prod;
  logic         out_valid;
  logic         out_ready;
  logic [408:0] out_res;
`ifdef GF409_REDUCE_PERF_EN
  logic [31:0]  out_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  logic [408:0] exp_q[$];

  gf409_reduce dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res)
`ifdef GF409_REDUCE_PERF_EN
    ,
    .out_count (out_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Schoolbook long division by x^409 + x^87 + 1, highest term first.
  function automatic logic [408:0] ref_mod(input logic [816:0] p);
    logic [816:0] r;
    r = p;
    for (int i = 816; i >= 409; i--) begin
      if (r[i]) begin
        r[i]       = 1'b0;
        r[i - 409] = r[i - 409] ^ 1'b1;
        r[i - 322] = r[i - 322] ^ 1'b1;
      end
    end
    return r[408:0];
  endfunction

  function automatic logic [816:0] rand_prod();
    logic [831:0] w;
    for (int k = 0; k < 26; k++) w[k*32 +: 32] = $urandom;
    return w[816:0];
  endfunction

  // Scoreboard: expectation pushed on accept, popped and compared on delivery.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(ref_mod(in_prod));
      if (out_valid && out_ready) begin
        n_out++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got %h required none", out_res);
        end else begin
          logic [408:0] e;
          e = exp_q.pop_front();
          if (out_res !== e) begin
            n_fail++;
            $display("FAIL sb_data: got %h required %h", out_res, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [816:0] p, output bit ok);
    in_prod  = p;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_prod = '0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ctrl: got out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    n_tests++;
    if (out_res !== '0) begin
      n_fail++;
      $display("FAIL reset_res: got %h required 0", out_res);
    end
`ifdef GF409_REDUCE_PERF_EN
    n_tests++;
    if (out_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d required 0", out_count);
    end
`endif
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed(input string name, input logic [816:0] p, input logic [408:0] e);
    out_ready = 1'b1;
    in_prod   = p;
    in_valid  = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_accept: got in_ready=%b required 1", name, in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_early: got out_valid=%b required 0", name, out_valid);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_res !== e) begin
      n_fail++;
      $display("FAIL %s_result: got valid=%b res=%h required valid=1 res=%h", name, out_valid, out_res, e);
    end
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    int base;
    bit ok;
    bit all_ok;
`ifdef GF409_REDUCE_PERF_EN
    logic [31:0] cnt0;
    cnt0 = out_count;
`endif
    base = n_out;
    all_ok = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      send(rand_prod(), ok);
      all_ok &= ok;
    end
    tick(); tick();
    n_tests++;
    if (!all_ok) begin
      n_fail++;
      $display("FAIL b2b_accept: got a stalled input required continuous acceptance");
    end
    n_tests++;
    if (n_out - base != 200 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results (%0d pending) required 200 (0)", n_out - base, exp_q.size());
    end
`ifdef GF409_REDUCE_PERF_EN
    n_tests++;
    if (out_count !== cnt0 + 32'd200) begin
      n_fail++;
      $display("FAIL b2b_perf: got %0d required %0d", out_count, cnt0 + 32'd200);
    end
`endif
  endtask

  task automatic test_stall();
    logic [816:0] prods [3];
    logic [408:0] snap;
    int idx;
    int base;
    bit acc;
    bit ok;
    for (int k = 0; k < 3; k++) prods[k] = rand_prod();
    base = n_out;
    out_ready = 1'b0;
    idx = 0;
    snap = '0;
    for (int c = 0; c < 5; c++) begin
      in_prod  = prods[idx < 3 ? idx : 2];
      in_valid = (idx < 3);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (c == 3) snap = out_res;
      tick();
      if (acc) idx++;
    end
    n_tests++;
    if (idx != 2 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_full: got accepted=%0d in_ready=%b required 2 0", idx, in_ready);
    end
    n_tests++;
    if (out_valid !== 1'b1 || out_res !== snap || out_res !== ref_mod(prods[0])) begin
      n_fail++;
      $display("FAIL stall_hold: got valid=%b res=%h required 1 %h", out_valid, out_res, ref_mod(prods[0]));
    end
    out_ready = 1'b1;
    send(prods[2], ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stall_third: got no accept required accept");
    end
    for (int c = 0; c < 4; c++) tick();
    n_tests++;
    if (n_out - base != 3 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_drain: got %0d results (%0d pending) required 3 (0)", n_out - base, exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    bit ok;
    bit seen;
    out_ready = 1'b0;
    send(rand_prod(), ok);
    send(rand_prod(), ok);
    n_tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_fill: got out_valid=%b in_ready=%b required 1 0", out_valid, in_ready);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: got out_valid=%b required 0", out_valid);
    end
    tick(); tick();
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_res !== '0) begin
      n_fail++;
      $display("FAIL rst_release: got in_ready=%b out_valid=%b res=%h required 1 0 0", in_ready, out_valid, out_res);
    end
`ifdef GF409_REDUCE_PERF_EN
    n_tests++;
    if (out_count !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_count: got %0d required 0", out_count);
    end
`endif
    out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL rst_stale: got out_valid=1 after reset required 0");
    end
  endtask

  initial begin
    logic [816:0] p;
    test_reset();
    p = '0; p[409] = 1'b1;
    test_directed("x409", p, 409'h1 | (409'h1 << 87));
    p = '0; p[816] = 1'b1;
    test_directed("x816", p, (409'h1 << 407) | (409'h1 << 172) | (409'h1 << 85));
    p = '0; p[15:0] = 16'h1234;
    test_directed("low", p, 409'h1234);
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
